music_sequencer: RTL and testbench
==================================

MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 Parameter BEAT_BASE, 6_250_000, base beat period in clk cycles (100 MHz clk, 1/16 s).
REQ-002 Parameter SONG_LEN, 64, beats per song; the song is a power of two, at most 256.
REQ-003 clk  in  1  system clock, 100 MHz; the only clock.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse; (re)start playback at beat 0.
REQ-006 pause_tgl  in  1  one-cycle pulse; toggle PLAY/PAUSE.
REQ-007 stop  in  1  one-cycle pulse; abort to IDLE.
REQ-008 loop_en  in  1  level; wrap to beat 0 at song end.
REQ-009 tempo_sel  in  2  beat period select.
REQ-010 note_div_left  out  22  divider for left buzzer channel.
REQ-011 note_div_right  out  22  divider for right buzzer channel.
REQ-012 beat_idx  out  8  current beat index.
REQ-013 busy  out  1  high in PLAY or PAUSE.
REQ-014 done  out  1  one-cycle pulse at non-looping song end.

Function
REQ-015 FSM states IDLE, PLAY, PAUSE; state, beat counter, cycle counter and all outputs are registered.
REQ-016 Event priority on a single cycle: stop > start > pause_tgl.
REQ-017 stop in any state -> IDLE; beat_idx=0; cycle counter=0.
REQ-018 start in IDLE or PAUSE -> PLAY at beat 0 with cycle counter 0; start in PLAY also restarts at beat 0.
REQ-019 pause_tgl in PLAY -> PAUSE with counters frozen; in PAUSE -> PLAY, resuming at the frozen count; ignored in IDLE.
REQ-020 Beat period P: tempo_sel 0 = 4*BEAT_BASE, 1 = 2*BEAT_BASE, 2 = BEAT_BASE, 3 = BEAT_BASE/2.
REQ-021 tempo_sel is latched into P only at beat start (entry to PLAY or beat advance); mid-beat changes take effect at the next beat.
REQ-022 In PLAY the cycle counter counts 0..P-1; at P-1 it clears and beat_idx increments.
REQ-023 When beat_idx = SONG_LEN-1 and the counter = P-1: if loop_en is 1, beat_idx wraps to 0 and play continues; otherwise -> IDLE, beat_idx=0, and done=1 for exactly that cycle.
REQ-024 Note codes are 5-bit: 0 = silence; 1..21 = C4..B6, seven diatonic notes per octave.
REQ-025 NOTE_DIV(code) = 100_000_000 / freq(code) truncated to 22 bits; NOTE_DIV(0) = NOTE_DIV_SILENCE = 22'd1.
REQ-026 In PLAY, outputs equal NOTE_DIV(rom code for beat_idx), registered with a latency of 1 cycle after a beat_idx change.
REQ-027 Articulation gap: when cycle counter >= P - (P>>3), both outputs are NOTE_DIV_SILENCE.
REQ-028 In IDLE and PAUSE, both note_div outputs are NOTE_DIV_SILENCE one cycle after state entry.
REQ-029 Left and right channels come from independent ROM fields and are looked up in the same cycle.

Reset
REQ-030 rst sampled high -> state IDLE, counters 0, beat_idx=0, busy=0, done=0, both note_div=NOTE_DIV_SILENCE, latched P = 4*BEAT_BASE.
REQ-031 rst has priority over all events; rst mid-PLAY aborts with no done pulse.

Structure
REQ-032 Package music_pkg holds the note-code width, the NOTE_DIV table (codes 0..21), NOTE_DIV_SILENCE, the state enum and the tempo_sel encodings.
REQ-033 Sub-module music_rom: combinational lookup, beat index in, 5-bit left and 5-bit right codes out, song contents fixed.
REQ-034 music_sequencer contains the FSM, the counters, the gap logic and the code-to-divider output registers.

Verification (BEAT_BASE=16, SONG_LEN=4, test ROM L={1,3,5,0}, R={8,0,8,0})
REQ-035 rst, then start, tempo_sel=2 -> busy=1 next cycle; beat_idx increments every 16 cycles; note_div_left silent for the last 2 cycles of each beat.
REQ-036 loop_en=0, play the full song -> exactly one done pulse at cycle 64 after start, then IDLE with outputs silent.
REQ-037 loop_en=1 -> beat_idx sequence 0,1,2,3,0,1; no done pulse.
REQ-038 pause_tgl at beat 1, cycle 5; hold 20 cycles; pause_tgl again -> outputs silent while paused; beat 1 resumes at cycle 5 and ends 11 cycles after resume.
REQ-039 stop and start in the same cycle during PLAY -> IDLE, beat_idx=0, busy=0; a simultaneous start and pause_tgl in IDLE -> PLAY.
REQ-040 tempo_sel changed from 2 to 0 mid-beat 0 -> beat 0 lasts 16 cycles and beat 1 lasts 64 cycles; rst mid-beat 2 -> all REQ-030 values, no done pulse.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types and constants for the music sequencer: note-code/divider widths,
// note divider table, FSM states and tempo_sel encodings.
package music_pkg;
    localparam int NOTE_W = 5;
    localparam int DIV_W  = 22;
    localparam int NUM_NOTES = 22;

    localparam logic [DIV_W-1:0] NOTE_DIV_SILENCE = 22'd1;

    // 100 MHz / note frequency, truncated; frequencies rounded to 0.01 Hz.
    // Codes 1..21 walk C4..B6 diatonically.
    localparam logic [DIV_W-1:0] NOTE_DIV [NUM_NOTES] = '{
        22'd1,
        22'd382219, 22'd340529, 22'd303370, 22'd286344, 22'd255102, 22'd227272, 22'd202478,
        22'd191113, 22'd170262, 22'd151687, 22'd143172, 22'd127552, 22'd113636, 22'd101238,
        22'd95556,  22'd85131,  22'd75843,  22'd71586,  22'd63776,  22'd56818,  22'd50619
    };

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_PAUSE} state_e;

    localparam logic [1:0] TEMPO_X4   = 2'd0;
    localparam logic [1:0] TEMPO_X2   = 2'd1;
    localparam logic [1:0] TEMPO_X1   = 2'd2;
    localparam logic [1:0] TEMPO_HALF = 2'd3;

    function automatic logic [DIV_W-1:0] note_div_of(input logic [NOTE_W-1:0] code);
        if (int'(code) >= NUM_NOTES) return NOTE_DIV_SILENCE;
        return NOTE_DIV[code];
    endfunction
endpackage

// File: rtl/music_rom.sv
// Fixed song ROM: a 16-beat phrase repeated over the song; beat index in,
// left and right note codes out (combinational).
module music_rom
    import music_pkg::*;
(
    input  logic [7:0]        beat_idx,
    output logic [NOTE_W-1:0] code_left,
    output logic [NOTE_W-1:0] code_right
);
    logic unused_hi;
    assign unused_hi = ^beat_idx[7:4];

    always_comb begin
        case (beat_idx[3:0])
            4'd0:    {code_left, code_right} = {5'd1,  5'd8};
            4'd1:    {code_left, code_right} = {5'd3,  5'd0};
            4'd2:    {code_left, code_right} = {5'd5,  5'd8};
            4'd3:    {code_left, code_right} = {5'd0,  5'd0};
            4'd4:    {code_left, code_right} = {5'd5,  5'd12};
            4'd5:    {code_left, code_right} = {5'd6,  5'd13};
            4'd6:    {code_left, code_right} = {5'd8,  5'd15};
            4'd7:    {code_left, code_right} = {5'd0,  5'd0};
            4'd8:    {code_left, code_right} = {5'd8,  5'd15};
            4'd9:    {code_left, code_right} = {5'd9,  5'd16};
            4'd10:   {code_left, code_right} = {5'd10, 5'd17};
            4'd11:   {code_left, code_right} = {5'd12, 5'd19};
            4'd12:   {code_left, code_right} = {5'd10, 5'd17};
            4'd13:   {code_left, code_right} = {5'd8,  5'd15};
            4'd14:   {code_left, code_right} = {5'd5,  5'd12};
            default: {code_left, code_right} = {5'd0,  5'd0};
        endcase
    end
endmodule

// File: rtl/music_sequencer.sv
// Beat sequencer: IDLE/PLAY/PAUSE FSM, beat/cycle counters, articulation gap and
// registered note dividers for two buzzer channels.
module music_sequencer
    import music_pkg::*;
#(
    parameter int BEAT_BASE = 6_250_000,
    parameter int SONG_LEN  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause_tgl,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [1:0]       tempo_sel,
    output logic [DIV_W-1:0] note_div_left,
    output logic [DIV_W-1:0] note_div_right,
    output logic [7:0]       beat_idx,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(4 * BEAT_BASE) + 1;
    localparam logic [7:0] LAST_BEAT = 8'(SONG_LEN - 1);

    state_e            st_q, st_d;
    logic [7:0]        beat_q, beat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, per_q, per_d, per_sel;
    logic [DIV_W-1:0]  ndl_q, ndl_d, ndr_q, ndr_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [NOTE_W-1:0] code_l, code_r;
    logic              beat_end, gap;

    music_rom u_rom (
        .beat_idx   (beat_q),
        .code_left  (code_l),
        .code_right (code_r)
    );

    always_comb begin
        case (tempo_sel)
            TEMPO_X4:   per_sel = CNT_W'(4 * BEAT_BASE);
            TEMPO_X2:   per_sel = CNT_W'(2 * BEAT_BASE);
            TEMPO_X1:   per_sel = CNT_W'(BEAT_BASE);
            default:    per_sel = CNT_W'(BEAT_BASE / 2);
        endcase
    end

    assign beat_end = (cnt_q == per_q - CNT_W'(1));
    assign gap      = (cnt_q >= per_q - (per_q >> 3));

    always_comb begin
        st_d   = st_q;
        beat_d = beat_q;
        cnt_d  = cnt_q;
        per_d  = per_q;
        done_d = 1'b0;
        if (stop) begin
            st_d   = ST_IDLE;
            beat_d = '0;
            cnt_d  = '0;
        end else if (start) begin
            st_d   = ST_PLAY;
            beat_d = '0;
            cnt_d  = '0;
            per_d  = per_sel;
        end else if (pause_tgl && st_q == ST_PLAY) begin
            st_d = ST_PAUSE;
        end else if (pause_tgl && st_q == ST_PAUSE) begin
            st_d = ST_PLAY;
        end else if (st_q == ST_PLAY) begin
            if (!beat_end) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = '0;
                per_d = per_sel;
                if (beat_q != LAST_BEAT) begin
                    beat_d = beat_q + 8'd1;
                end else if (loop_en) begin
                    beat_d = '0;
                end else begin
                    st_d   = ST_IDLE;
                    beat_d = '0;
                    done_d = 1'b1;
                end
            end
        end
        busy_d = (st_d != ST_IDLE);
        // Dividers follow the current registered state, so they trail it by one cycle.
        ndl_d = NOTE_DIV_SILENCE;
        ndr_d = NOTE_DIV_SILENCE;
        if (st_q == ST_PLAY && !gap) begin
            ndl_d = note_div_of(code_l);
            ndr_d = note_div_of(code_r);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            beat_q <= '0;
            cnt_q  <= '0;
            per_q  <= CNT_W'(4 * BEAT_BASE);
            ndl_q  <= NOTE_DIV_SILENCE;
            ndr_q  <= NOTE_DIV_SILENCE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            beat_q <= beat_d;
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            ndl_q  <= ndl_d;
            ndr_q  <= ndr_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign note_div_left  = ndl_q;
    assign note_div_right = ndr_q;
    assign beat_idx       = beat_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer: event-priority table, directed timing
// sequences and random stimulus against a beat-level reference model.
module tb_music_sequencer;
    localparam int BB  = 16;
    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0, start = 1'b0, pause_tgl = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [1:0]  tempo_sel = 2'd2;
    logic [21:0] note_div_left, note_div_right;
    logic [7:0]  beat_idx;
    logic        busy, done;

    music_sequencer #(.BEAT_BASE(BB), .SONG_LEN(LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .pause_tgl(pause_tgl), .stop(stop),
        .loop_en(loop_en), .tempo_sel(tempo_sel),
        .note_div_left(note_div_left), .note_div_right(note_div_right),
        .beat_idx(beat_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    // Reference: test song and standard note frequencies.
    int  ROM_L [LEN] = '{1, 3, 5, 0};
    int  ROM_R [LEN] = '{8, 0, 8, 0};
    real FREQ [22] = '{0.0,
        261.63, 293.66, 329.63, 349.23, 392.00, 440.00, 493.88,
        523.25, 587.33, 659.25, 698.46, 783.99, 880.00, 987.77,
        1046.50, 1174.66, 1318.51, 1396.91, 1567.98, 1760.00, 1975.53};

    function automatic int div_of(input int code);
        if (code == 0) return 1;
        return $rtoi(1.0e8 / FREQ[code]);
    endfunction

    function automatic int period_of(input int ts);
        return (4 * BB) >> ts;
    endfunction

    // Model: mode 0 idle, 1 playing, 2 paused; pos = cycles elapsed in beat.
    int m_mode = 0, m_beat = 0, m_pos = 0, m_per = 4 * BB, m_done = 0;
    int m_nl = 1, m_nr = 1;
    int done_seen = 0;

    task automatic model_step(input bit r, s, p, t);
        if (r) begin
            m_mode = 0; m_beat = 0; m_pos = 0; m_per = 4 * BB; m_done = 0;
            m_nl = 1; m_nr = 1;
            return;
        end
        if (m_mode == 1 && m_pos < m_per - m_per / 8) begin
            m_nl = div_of(ROM_L[m_beat]);
            m_nr = div_of(ROM_R[m_beat]);
        end else begin
            m_nl = 1; m_nr = 1;
        end
        m_done = 0;
        if (t) begin
            m_mode = 0; m_beat = 0; m_pos = 0;
        end else if (s) begin
            m_mode = 1; m_beat = 0; m_pos = 0; m_per = period_of(int'(tempo_sel));
        end else if (p && m_mode != 0) begin
            m_mode = (m_mode == 1) ? 2 : 1;
        end else if (m_mode == 1) begin
            m_pos++;
            if (m_pos == m_per) begin
                m_pos = 0;
                m_per = period_of(int'(tempo_sel));
                m_beat++;
                if (m_beat == LEN) begin
                    m_beat = 0;
                    if (!loop_en) begin m_mode = 0; m_done = 1; end
                end
            end
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // One clock: drive pulses away from the edge, step the model, sample 1 ns later.
    task automatic cyc(input bit r, s, p, t);
        rst = r; start = s; pause_tgl = p; stop = t;
        @(posedge clk);
        model_step(r, s, p, t);
        #1;
        rst = 1'b0; start = 1'b0; pause_tgl = 1'b0; stop = 1'b0;
        if (done) done_seen++;
        chk("beat_idx", beat_idx, m_beat);
        chk("busy", busy, m_mode != 0);
        chk("done", done, m_done);
        chk("note_l", note_div_left, m_nl);
        chk("note_r", note_div_right, m_nr);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic edges_until_beat(input int b, output int n);
        n = 0;
        do begin cyc(0, 0, 0, 0); n++; end while (beat_idx != 8'(b) && n < 500);
    endtask

    typedef struct {
        bit r, s, p, t;
        bit e_busy;
        int e_beat;
        bit e_done;
    } vec_t;

    vec_t tbl [10];
    int n;

    initial begin
        tbl = '{
            '{1, 0, 0, 0, 0, 0, 0},   // reset
            '{0, 0, 1, 0, 0, 0, 0},   // pause ignored in idle
            '{0, 1, 1, 0, 1, 0, 0},   // start beats pause
            '{0, 0, 0, 0, 1, 0, 0},
            '{0, 0, 1, 0, 1, 0, 0},   // into pause
            '{0, 1, 1, 0, 1, 0, 0},   // start from pause
            '{0, 1, 0, 1, 0, 0, 0},   // stop beats start
            '{0, 1, 0, 0, 1, 0, 0},
            '{0, 0, 1, 1, 0, 0, 0},   // stop beats pause
            '{1, 1, 0, 0, 0, 0, 0}    // reset beats start
        };
        tempo_sel = 2'd2; loop_en = 1'b0;
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].t);
            chk("tbl_busy", busy, tbl[i].e_busy);
            chk("tbl_beat", beat_idx, tbl[i].e_beat);
            chk("tbl_done", done, tbl[i].e_done);
        end
        chk("rst_note_l", note_div_left, 1);
        chk("rst_note_r", note_div_right, 1);

        // Full song without loop: done exactly 64 edges after start, once.
        done_seen = 0;
        cyc(0, 1, 0, 0);
        chk("start_busy", busy, 1);
        n = 0;
        do begin cyc(0, 0, 0, 0); n++; end while (!done && n < 200);
        chk("done_at", n, 64);
        idle_n(8);
        chk("done_count", done_seen, 1);
        chk("end_busy", busy, 0);
        chk("end_note_l", note_div_left, 1);

        // Loop: beat sequence 0,1,2,3,0,1 with no done.
        loop_en = 1'b1; done_seen = 0;
        cyc(0, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            chk("loop_beat", beat_idx, k % 4);
            idle_n(16);
        end
        chk("loop_done", done_seen, 0);
        cyc(0, 0, 0, 1);
        loop_en = 1'b0;

        // Pause at beat 1 cycle 5, hold 20, resume; beat 1 ends 11 edges later.
        cyc(0, 1, 0, 0);
        idle_n(21);
        cyc(0, 0, 1, 0);
        idle_n(20);
        chk("pause_beat", beat_idx, 1);
        chk("pause_silent", note_div_left, 1);
        cyc(0, 0, 1, 0);
        edges_until_beat(2, n);
        chk("resume_len", n, 11);

        // Stop and start together mid-play.
        cyc(0, 1, 1, 1);
        chk("stopstart_busy", busy, 0);
        chk("stopstart_beat", beat_idx, 0);

        // Tempo change mid-beat 0 applies from beat 1.
        tempo_sel = 2'd2;
        cyc(0, 1, 0, 0);
        idle_n(5);
        tempo_sel = 2'd0;
        edges_until_beat(1, n);
        chk("beat0_len", n + 5, 16);
        edges_until_beat(2, n);
        chk("beat1_len", n, 64);
        idle_n(10);
        done_seen = 0;
        cyc(1, 0, 0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_beat", beat_idx, 0);
        chk("rst_note_l2", note_div_left, 1);
        idle_n(3);
        chk("rst_nodone", done_seen, 0);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                tempo_sel = 2'($urandom_range(3));
                loop_en   = 1'($urandom_range(1));
            end
            cyc($urandom_range(299) == 0, $urandom_range(119) == 0,
                $urandom_range(59) == 0, $urandom_range(249) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
